ysyx_25040129_wbu: RTL and testbench
====================================

Name: ysyx_25040129_wbu

Overview:
- Write-back/commit stage directly downstream of the LSU.
- Accepts one retiring instruction per valid/ready handshake. Writes the GPR file and the machine CSRs.
- Generates a registered PC redirect to the IFU for taken branches, ecall, mret and fence.i.
- Provides combinational GPR and CSR read ports to the IDU/EXU, and counts retired instructions.

Parameters:
- NREGS, 16, number of GPRs (RV32E); x0 hardwired to zero.
- RA_W, 4, GPR index width (log2 NREGS).
- CSR_AW, 12, CSR address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- is_req_valid_from_lsu  in  1  LSU offers a retiring instruction
- is_req_ready_to_lsu  out  1  WBU can accept this cycle
- pc_in  in  32  PC of the offered instruction
- result_in  in  32  value written to rd (ALU result, load data, or old CSR value)
- reg_write_in  in  1  write rd
- rd_in  in  RA_W  destination GPR
- csr_write_in  in  1  write CSR
- csr_addr_in  in  CSR_AW  CSR to write
- csr_wdata_in  in  32  new CSR value
- ecall_in  in  1  instruction is ecall
- mret_in  in  1  instruction is mret
- is_branch_in  in  1  control transfer taken (jal/jalr/taken branch)
- branch_target_in  in  32  target when is_branch_in
- fence_i_in  in  1  instruction is fence.i
- rs1_addr  in  RA_W  read port 1 index
- rs1_data  out  32  read port 1 data
- rs2_addr  in  RA_W  read port 2 index
- rs2_data  out  32  read port 2 data
- csr_raddr  in  CSR_AW  CSR read index
- csr_rdata  out  32  CSR read data
- redirect_valid  out  1  one-cycle redirect pulse to IFU
- redirect_pc  out  32  redirect target
- fence_i_flush  out  1  one-cycle I-cache invalidate pulse
- retire_count  out  32  retired-instruction counter

Behaviour:
- Commit: commit = is_req_valid_from_lsu && is_req_ready_to_lsu. All architectural updates occur at the commit clock edge.
- States:
  - RUN: ready = 1.
  - REDIRECT: ready = 0; redirect_valid = 1 for exactly one cycle.
  - Transitions: RUN -> REDIRECT on commit with any of ecall/mret/is_branch/fence_i; REDIRECT -> RUN unconditionally; otherwise stay in RUN.
- Redirect target, latched at commit. Priority: ecall > mret > is_branch > fence_i.
  - ecall: mtvec.
  - mret: mepc. Uses the value before any same-commit CSR write.
  - is_branch: branch_target_in.
  - fence_i: pc_in + 4, wrapping mod 2^32. fence_i_flush pulses in the same cycle as redirect_valid, whenever fence_i_in was set at commit, regardless of priority.
- GPR file:
  - Write on commit when reg_write_in && rd_in != 0.
  - x0 always reads 0.
  - Read ports are combinational with write bypass: if commit writes rdX == rsN_addr (nonzero), rsN_data = result_in in the same cycle.
- CSRs (only these exist):
  - mstatus 0x300: reset 0x0000_1800.
  - mtvec 0x305: reset 0; bits [1:0] forced to 0 on write.
  - mepc 0x341: reset 0; bits [1:0] forced to 0.
  - mcause 0x342: reset 0.
  - Writes to any other address are ignored; reads of other addresses return 0. csr_rdata does not bypass.
- CSR side effects and ordering:
  - ecall: mepc <= pc_in, mcause <= 11, mstatus.MPIE <= MIE, MIE <= 0.
  - mret: MIE <= MPIE, MPIE <= 1; MPP stays 2'b11.
  - Ordering at one commit: the explicit csr_write is applied first, then ecall/mret side effects override the fields they touch.
- retire_count: +1 on every commit, wraps at 2^32.
- Reset values: ready = 1; redirect_valid = 0; redirect_pc = 0; fence_i_flush = 0; retire_count = 0; all GPRs = 0; state = RUN. rst overrides any in-flight commit or pending redirect, so no pulse occurs after reset.
- Consecutive commits:
  - Non-control instructions commit every cycle.
  - A control instruction blocks exactly one cycle. While ready = 0, the LSU holds its outputs and no state changes.

Test Plan:
- Reset, then commit addi with rd=5, result=0x1234 -> next cycle rs1_addr=5 gives 0x1234; retire_count=1; redirect_valid stays 0. Same-cycle bypass: rs1_addr=5 during the commit shows 0x1234.
- Commit with rd=0, reg_write=1, result=0xFFFF_FFFF -> rs1_addr=0 reads 0.
- Write mtvec=0x8000_0103 via csr_write; then commit ecall at pc=0x8000_0040 ->
  - redirect_valid pulses once with redirect_pc=0x8000_0100, and ready=0 that cycle.
  - mepc=0x8000_0040, mcause=11.
  - Next commit accepted the following cycle.
- Commit mret after ecall -> redirect_pc=0x8000_0040; mstatus.MIE restored from MPIE; MPIE=1.
- Commit fence.i at pc=0xFFFF_FFFC -> redirect_pc=0x0000_0000 and fence_i_flush=1 in the same single cycle. Commit with both is_branch (target 0x100) and fence_i -> redirect_pc=0x100 and fence_i_flush=1.
- Assert rst in the cycle after a branch commit -> redirect_valid=0, ready=1, retire_count=0, all GPRs read 0.

Source files
------------

// File: rtl/ysyx_25040129_wbu.sv
// Write-back/commit stage: retires one instruction per handshake, updates the
// GPR file and machine CSRs, and issues a one-cycle PC redirect to the IFU.
module ysyx_25040129_wbu #(
    parameter int unsigned NREGS  = 16,
    parameter int unsigned RA_W   = 4,
    parameter int unsigned CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              is_req_valid_from_lsu,
    output logic              is_req_ready_to_lsu,
    input  logic [31:0]       pc_in,
    input  logic [31:0]       result_in,
    input  logic              reg_write_in,
    input  logic [RA_W-1:0]   rd_in,
    input  logic              csr_write_in,
    input  logic [CSR_AW-1:0] csr_addr_in,
    input  logic [31:0]       csr_wdata_in,
    input  logic              ecall_in,
    input  logic              mret_in,
    input  logic              is_branch_in,
    input  logic [31:0]       branch_target_in,
    input  logic              fence_i_in,
    input  logic [RA_W-1:0]   rs1_addr,
    output logic [31:0]       rs1_data,
    input  logic [RA_W-1:0]   rs2_addr,
    output logic [31:0]       rs2_data,
    input  logic [CSR_AW-1:0] csr_raddr,
    output logic [31:0]       csr_rdata,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    output logic              fence_i_flush,
    output logic [31:0]       retire_count
);

    localparam logic [CSR_AW-1:0] CSR_MSTATUS = CSR_AW'(12'h300);
    localparam logic [CSR_AW-1:0] CSR_MTVEC   = CSR_AW'(12'h305);
    localparam logic [CSR_AW-1:0] CSR_MEPC    = CSR_AW'(12'h341);
    localparam logic [CSR_AW-1:0] CSR_MCAUSE  = CSR_AW'(12'h342);

    localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;
    localparam int unsigned MIE_BIT  = 3;
    localparam int unsigned MPIE_BIT = 7;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        fence_i_flush_q, fence_i_flush_d;
    logic [31:0] retire_count_q, retire_count_d;
    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] gpr_q [NREGS];
    logic [31:0] gpr_d [NREGS];

    logic commit;
    logic is_ctrl;
    logic gpr_wen;

    assign is_req_ready_to_lsu = (state_q == ST_RUN);
    assign commit  = is_req_valid_from_lsu && is_req_ready_to_lsu;
    assign is_ctrl = ecall_in || mret_in || is_branch_in || fence_i_in;
    assign gpr_wen = commit && reg_write_in && (rd_in != '0);

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign fence_i_flush  = fence_i_flush_q;
    assign retire_count   = retire_count_q;

    // Control FSM: a control commit costs exactly one bubble cycle carrying the redirect.
    always_comb begin
        state_d          = state_q;
        redirect_valid_d = 1'b0;
        fence_i_flush_d  = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        unique case (state_q)
            ST_RUN: begin
                if (commit && is_ctrl) begin
                    state_d          = ST_REDIRECT;
                    redirect_valid_d = 1'b1;
                    fence_i_flush_d  = fence_i_in;
                    if (ecall_in) begin
                        redirect_pc_d = mtvec_q;
                    end else if (mret_in) begin
                        redirect_pc_d = mepc_q;
                    end else if (is_branch_in) begin
                        redirect_pc_d = branch_target_in;
                    end else begin
                        redirect_pc_d = pc_in + 32'd4;
                    end
                end
            end
            ST_REDIRECT: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // CSR update: explicit write first, then ecall/mret field overrides.
    always_comb begin
        mstatus_d = mstatus_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        if (commit && csr_write_in) begin
            case (csr_addr_in)
                CSR_MSTATUS: mstatus_d = csr_wdata_in;
                CSR_MTVEC:   mtvec_d   = {csr_wdata_in[31:2], 2'b00};
                CSR_MEPC:    mepc_d    = {csr_wdata_in[31:2], 2'b00};
                CSR_MCAUSE:  mcause_d  = csr_wdata_in;
                default: ;
            endcase
        end
        if (commit && ecall_in) begin
            mepc_d              = {pc_in[31:2], 2'b00};
            mcause_d            = 32'd11;
            mstatus_d[MPIE_BIT] = mstatus_d[MIE_BIT];
            mstatus_d[MIE_BIT]  = 1'b0;
        end else if (commit && mret_in) begin
            mstatus_d[MIE_BIT]  = mstatus_d[MPIE_BIT];
            mstatus_d[MPIE_BIT] = 1'b1;
            mstatus_d[12:11]    = 2'b11;
        end
    end

    // GPR next state and retire counter.
    always_comb begin
        for (int i = 0; i < int'(NREGS); i++) begin
            gpr_d[i] = gpr_q[i];
        end
        if (gpr_wen) begin
            gpr_d[rd_in] = result_in;
        end
        retire_count_d = retire_count_q + (commit ? 32'd1 : 32'd0);
    end

    // Combinational GPR read ports with same-cycle write bypass; x0 reads zero.
    always_comb begin
        rs1_data = 32'd0;
        rs2_data = 32'd0;
        if (rs1_addr != '0) begin
            rs1_data = (gpr_wen && rd_in == rs1_addr) ? result_in : gpr_q[rs1_addr];
        end
        if (rs2_addr != '0) begin
            rs2_data = (gpr_wen && rd_in == rs2_addr) ? result_in : gpr_q[rs2_addr];
        end
    end

    // CSR read port, no bypass; unimplemented addresses read zero.
    always_comb begin
        csr_rdata = 32'd0;
        case (csr_raddr)
            CSR_MSTATUS: csr_rdata = mstatus_q;
            CSR_MTVEC:   csr_rdata = mtvec_q;
            CSR_MEPC:    csr_rdata = mepc_q;
            CSR_MCAUSE:  csr_rdata = mcause_q;
            default: ;
        endcase
    end

    // State registers; reset discards any in-flight commit or pending redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_RUN;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            fence_i_flush_q  <= 1'b0;
            retire_count_q   <= 32'd0;
            mstatus_q        <= MSTATUS_RST;
            mtvec_q          <= 32'd0;
            mepc_q           <= 32'd0;
            mcause_q         <= 32'd0;
            for (int i = 0; i < int'(NREGS); i++) begin
                gpr_q[i] <= 32'd0;
            end
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            fence_i_flush_q  <= fence_i_flush_d;
            retire_count_q   <= retire_count_d;
            mstatus_q        <= mstatus_d;
            mtvec_q          <= mtvec_d;
            mepc_q           <= mepc_d;
            mcause_q         <= mcause_d;
            for (int i = 0; i < int'(NREGS); i++) begin
                gpr_q[i] <= gpr_d[i];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25040129_wbu.sv
// Scoreboard bench for the write-back stage: expected redirects are queued at
// issue time and popped by a monitor whenever the DUT pulses redirect_valid.
module tb_ysyx_25040129_wbu;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        ready;
    logic [31:0] pc_in, result_in, csr_wdata_in, branch_target_in;
    logic        reg_write_in, csr_write_in, ecall_in, mret_in, is_branch_in, fence_i_in;
    logic [3:0]  rd_in, rs1_addr, rs2_addr;
    logic [11:0] csr_addr_in, csr_raddr;
    logic [31:0] rs1_data, rs2_data, csr_rdata, redirect_pc, retire_count;
    logic        redirect_valid, fence_i_flush;

    typedef struct {
        logic [31:0] pc;
        logic        flush;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   waits;

    ysyx_25040129_wbu dut (
        .clk                  (clk),
        .rst                  (rst),
        .is_req_valid_from_lsu(valid),
        .is_req_ready_to_lsu  (ready),
        .pc_in                (pc_in),
        .result_in            (result_in),
        .reg_write_in         (reg_write_in),
        .rd_in                (rd_in),
        .csr_write_in         (csr_write_in),
        .csr_addr_in          (csr_addr_in),
        .csr_wdata_in         (csr_wdata_in),
        .ecall_in             (ecall_in),
        .mret_in              (mret_in),
        .is_branch_in         (is_branch_in),
        .branch_target_in     (branch_target_in),
        .fence_i_in           (fence_i_in),
        .rs1_addr             (rs1_addr),
        .rs1_data             (rs1_data),
        .rs2_addr             (rs2_addr),
        .rs2_data             (rs2_data),
        .csr_raddr            (csr_raddr),
        .csr_rdata            (csr_rdata),
        .redirect_valid       (redirect_valid),
        .redirect_pc          (redirect_pc),
        .fence_i_flush        (fence_i_flush),
        .retire_count         (retire_count)
    );

    always #20 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every redirect pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (redirect_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_redirect", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("redirect_pc", redirect_pc, e.pc);
                check("fence_i_flush", 32'(fence_i_flush), 32'(e.flush));
                check("ready_during_redirect", 32'(ready), 32'd0);
            end
        end else if (fence_i_flush) begin
            check("flush_without_redirect", 32'd1, 32'd0);
        end
    end

    task automatic expect_redirect(input logic [31:0] pc, input logic flush);
        exp_t e;
        e.pc = pc;
        e.flush = flush;
        exp_q.push_back(e);
    endtask

    task automatic clear_inputs();
        valid = 1'b0; pc_in = '0; result_in = '0; reg_write_in = 1'b0; rd_in = '0;
        csr_write_in = 1'b0; csr_addr_in = '0; csr_wdata_in = '0; ecall_in = 1'b0;
        mret_in = 1'b0; is_branch_in = 1'b0; branch_target_in = '0; fence_i_in = 1'b0;
    endtask

    // Offer one instruction at the negedge, waiting (bounded) for ready.
    task automatic send(input logic [31:0] pc, input logic [31:0] res, input logic rw,
                        input logic [3:0] rd, input logic cw, input logic [11:0] ca,
                        input logic [31:0] cd, input logic ec, input logic mr,
                        input logic br, input logic [31:0] bt, input logic fi,
                        output int nwait);
        @(negedge clk);
        clear_inputs();
        valid = 1'b1; pc_in = pc; result_in = res; reg_write_in = rw; rd_in = rd;
        csr_write_in = cw; csr_addr_in = ca; csr_wdata_in = cd; ecall_in = ec;
        mret_in = mr; is_branch_in = br; branch_target_in = bt; fence_i_in = fi;
        nwait = 0;
        #1;
        while (!ready && nwait < 8) begin
            @(negedge clk);
            nwait++;
            #1;
        end
        if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic idle();
        @(negedge clk);
        clear_inputs();
        #1;
    endtask

    task automatic rd_gpr(input string name, input logic [3:0] a, input logic [31:0] exp);
        rs1_addr = a;
        rs2_addr = a;
        #1;
        check({name, "_rs1"}, rs1_data, exp);
        check({name, "_rs2"}, rs2_data, exp);
    endtask

    task automatic rd_csr(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_raddr = a;
        #1;
        check(name, csr_rdata, exp);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        rs1_addr = '0; rs2_addr = '0; csr_raddr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_flush", 32'(fence_i_flush), 32'd0);
        check("rst_retire", retire_count, 32'd0);
        rd_csr("rst_mstatus", 12'h300, 32'h0000_1800);
        rd_gpr("rst_x5", 4'd5, 32'd0);

        // addi x5 = 0x1234, with same-cycle bypass
        send(32'h8000_0000, 32'h1234, 1'b1, 4'd5, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, waits);
        rd_gpr("bypass_x5", 4'd5, 32'h1234);
        idle();
        rd_gpr("x5", 4'd5, 32'h1234);
        check("retire_1", retire_count, 32'd1);

        // write to x0 is dropped, including on the bypass path
        send(32'h8000_0004, 32'hFFFF_FFFF, 1'b1, 4'd0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, waits);
        rd_gpr("bypass_x0", 4'd0, 32'd0);
        idle();
        rd_gpr("x0", 4'd0, 32'd0);
        check("retire_2", retire_count, 32'd2);

        // CSR writes: mtvec alignment, ignored address, mstatus.MIE set
        send(32'h8000_0008, '0, 1'b0, '0, 1'b1, 12'h305, 32'h8000_0103, 1'b0, 1'b0, 1'b0, '0, 1'b0, waits);
        send(32'h8000_000C, '0, 1'b0, '0, 1'b1, 12'h340, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, '0, 1'b0, waits);
        send(32'h8000_0010, '0, 1'b0, '0, 1'b1, 12'h300, 32'h0000_1808, 1'b0, 1'b0, 1'b0, '0, 1'b0, waits);
        check("back_to_back_waits", 32'(waits), 32'd0);
        idle();
        rd_csr("mtvec", 12'h305, 32'h8000_0100);
        rd_csr("unimpl_csr", 12'h340, 32'd0);
        rd_csr("mstatus_w", 12'h300, 32'h0000_1808);
        check("retire_5", retire_count, 32'd5);

        // ecall, then an addi that must wait exactly one cycle
        expect_redirect(32'h8000_0100, 1'b0);
        send(32'h8000_0040, '0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0, waits);
        send(32'h8000_0100, 32'h66, 1'b1, 4'd6, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, waits);
        check("ecall_bubble_waits", 32'(waits), 32'd1);
        idle();
        rd_csr("ecall_mepc", 12'h341, 32'h8000_0040);
        rd_csr("ecall_mcause", 12'h342, 32'd11);
        rd_csr("ecall_mstatus", 12'h300, 32'h0000_1880);
        rd_gpr("x6", 4'd6, 32'h66);
        check("retire_7", retire_count, 32'd7);

        // mret returns to mepc and restores MIE
        expect_redirect(32'h8000_0040, 1'b0);
        send(32'h8000_0104, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0, waits);
        idle();
        idle();
        rd_csr("mret_mstatus", 12'h300, 32'h0000_1888);
        check("retire_8", retire_count, 32'd8);

        // fence.i at top of address space wraps to 0
        expect_redirect(32'h0000_0000, 1'b1);
        send(32'hFFFF_FFFC, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1, waits);
        idle();
        idle();

        // branch outranks fence.i for the target, flush still pulses
        expect_redirect(32'h0000_0100, 1'b1);
        send(32'h0000_0200, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, waits);
        idle();
        idle();
        check("retire_10", retire_count, 32'd10);

        // reset in the redirect cycle after a branch, with a control instr still offered
        expect_redirect(32'h0000_0300, 1'b0);
        send(32'h0000_0400, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0, waits);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst2_ready", 32'(ready), 32'd1);
        check("rst2_redirect_valid", 32'(redirect_valid), 32'd0);
        check("rst2_retire", retire_count, 32'd0);
        check("rst2_redirect_pc", redirect_pc, 32'd0);
        rd_csr("rst2_mtvec", 12'h305, 32'd0);
        for (int i = 1; i < 16; i++) begin
            rd_gpr("rst2_gpr", 4'(i), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        idle();
        check("post_rst_retire", retire_count, 32'd0);
        check("post_rst_redirect_valid", 32'(redirect_valid), 32'd0);
        idle();
        idle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
